// File: rtl/generic_memory_pkg.sv
// Shared types and sizing helpers for the generic_memory family.
package generic_memory_pkg;

    typedef enum logic {WM_READ_FIRST, WM_WRITE_FIRST} write_mode_e;

    localparam int MAX_READ_LATENCY = 4;

    function automatic int word_addr_width(input int addr_width, input int data_width);
        return addr_width - $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/generic_memory_rd_pipe.sv
// Per-port read-return pipeline: valid/data shift stages ending in a holding Q register.
module generic_memory_rd_pipe
    import generic_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  launch,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  rvalid
);

    localparam int LAT = (READ_LATENCY < 1) ? 1 :
                         (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

    logic [LAT-1:0]                 vld_q, vld_d;
    logic [LAT-1:0][DATA_WIDTH-1:0] data_q, data_d;

    // Each stage only loads when a result moves into it, so the last stage holds Q between reads
    always_comb begin
        vld_d     = '0;
        data_d    = data_q;
        vld_d[0]  = launch;
        if (launch) begin
            data_d[0] = rd_data;
        end
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign q      = data_q[LAT-1];
    assign rvalid = vld_q[LAT-1];

endmodule

// File: rtl/generic_memory_dp.sv
// True dual-port byte-writable RAM with configurable read latency and defined cross-port collisions.
module generic_memory_dp
    import generic_memory_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          DATA_WIDTH   = 32,
    localparam int         BE_WIDTH     = DATA_WIDTH / 8,
    parameter int          READ_LATENCY = 1,
    parameter write_mode_e WRITE_MODE   = WM_READ_FIRST,
    parameter bit          INIT_ZERO    = 1'b0
) (
    input  logic                  CLK,
    input  logic                  INITN,
    input  logic                  CEN_A,
    input  logic                  WEN_A,
    input  logic [ADDR_WIDTH-1:0] A_A,
    input  logic [DATA_WIDTH-1:0] D_A,
    input  logic [BE_WIDTH-1:0]   BEN_A,
    output logic [DATA_WIDTH-1:0] Q_A,
    output logic                  RVALID_A,
    input  logic                  CEN_B,
    input  logic                  WEN_B,
    input  logic [ADDR_WIDTH-1:0] A_B,
    input  logic [DATA_WIDTH-1:0] D_B,
    input  logic [BE_WIDTH-1:0]   BEN_B,
    output logic [DATA_WIDTH-1:0] Q_B,
    output logic                  RVALID_B
);

    localparam int OFFS  = $clog2(BE_WIDTH);
    localparam int WAW   = word_addr_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int DEPTH = 2 ** WAW;
    localparam logic [DATA_WIDTH-1:0] INIT_WORD = INIT_ZERO ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bx}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_WORD};

    logic [WAW-1:0]        idx_a, idx_b;
    logic                  wr_a, wr_b, rd_a, rd_b, collide;
    logic [DATA_WIDTH-1:0] old_a, old_b, wdata_a, wdata_b, rdata_a, rdata_b;

    generate
        if (OFFS > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^{A_A[OFFS-1:0], A_B[OFFS-1:0]};
        end
    endgenerate

    // On a same-word double write, port A's merged word carries B's bytes wherever A leaves a byte alone
    always_comb begin
        idx_a   = A_A[ADDR_WIDTH-1:OFFS];
        idx_b   = A_B[ADDR_WIDTH-1:OFFS];
        wr_a    = ~CEN_A & ~WEN_A;
        wr_b    = ~CEN_B & ~WEN_B;
        rd_a    = ~CEN_A & (WEN_A | (WRITE_MODE == WM_WRITE_FIRST));
        rd_b    = ~CEN_B & (WEN_B | (WRITE_MODE == WM_WRITE_FIRST));
        collide = wr_a & wr_b & (idx_a == idx_b);
        old_a   = mem_q[idx_a];
        old_b   = mem_q[idx_b];
        wdata_a = old_a;
        wdata_b = old_b;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (BEN_A[i]) begin
                wdata_a[i*8 +: 8] = D_A[i*8 +: 8];
            end else if (collide && BEN_B[i]) begin
                wdata_a[i*8 +: 8] = D_B[i*8 +: 8];
            end
            if (BEN_B[i]) begin
                wdata_b[i*8 +: 8] = D_B[i*8 +: 8];
            end
        end
        if (collide) begin
            wdata_b = wdata_a;
        end
        rdata_a = wr_a ? wdata_a : old_a;
        rdata_b = wr_b ? wdata_b : old_b;
    end

    always_ff @(posedge CLK) begin
        if (INITN && wr_a) begin
            mem_q[idx_a] <= wdata_a;
        end
        if (INITN && wr_b && !collide) begin
            mem_q[idx_b] <= wdata_b;
        end
    end

    generic_memory_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe_a (
        .clk    (CLK),
        .rst_n  (INITN),
        .launch (rd_a),
        .rd_data(rdata_a),
        .q      (Q_A),
        .rvalid (RVALID_A)
    );

    generic_memory_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe_b (
        .clk    (CLK),
        .rst_n  (INITN),
        .launch (rd_b),
        .rd_data(rdata_b),
        .q      (Q_B),
        .rvalid (RVALID_B)
    );

endmodule

// File: tb/tb_generic_memory_dp.sv
// Scoreboard bench for generic_memory_dp: latency 3, write-first, zero-initialised array.
module tb_generic_memory_dp;
    import generic_memory_pkg::*;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 3;

    logic          CLK = 1'b0;
    logic          INITN = 1'b0;
    logic          CEN_A, WEN_A, CEN_B, WEN_B;
    logic [AW-1:0] A_A, A_B;
    logic [DW-1:0] D_A, D_B, Q_A, Q_B;
    logic [BW-1:0] BEN_A, BEN_B;
    logic          RVALID_A, RVALID_B;

    generic_memory_dp #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(LAT),
        .WRITE_MODE  (WM_WRITE_FIRST),
        .INIT_ZERO   (1'b1)
    ) dut (
        .CLK(CLK), .INITN(INITN),
        .CEN_A(CEN_A), .WEN_A(WEN_A), .A_A(A_A), .D_A(D_A), .BEN_A(BEN_A), .Q_A(Q_A), .RVALID_A(RVALID_A),
        .CEN_B(CEN_B), .WEN_B(WEN_B), .A_B(A_B), .D_B(D_B), .BEN_B(BEN_B), .Q_B(Q_B), .RVALID_B(RVALID_B)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic void chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    endfunction

    task automatic idle();
        CEN_A = 1'b1; WEN_A = 1'b1; A_A = AW'($urandom); D_A = $urandom; BEN_A = BW'($urandom);
        CEN_B = 1'b1; WEN_B = 1'b1; A_B = AW'($urandom); D_B = $urandom; BEN_B = BW'($urandom);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic op_a(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                        input logic [BW-1:0] ben, input logic [DW-1:0] exp, input bit push);
        CEN_A = 1'b0; WEN_A = wen; A_A = addr; D_A = d; BEN_A = ben;
        if (push) qa.push_back('{data: exp, due: cyc + LAT});
    endtask

    task automatic op_b(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                        input logic [BW-1:0] ben, input logic [DW-1:0] exp, input bit push);
        CEN_B = 1'b0; WEN_B = wen; A_B = addr; D_B = d; BEN_B = ben;
        if (push) qb.push_back('{data: exp, due: cyc + LAT});
    endtask

    always @(negedge CLK) begin
        if (INITN) begin
            if (RVALID_A) begin
                if (qa.size() == 0) begin
                    n_tot++;
                    $display("FAIL A_unexpected_rvalid: Q_A=0x%08h, expected no result at cycle %0d", Q_A, cyc);
                end else begin
                    ea = qa.pop_front();
                    chk("A_data", Q_A, ea.data);
                    chk("A_latency", DW'(cyc), DW'(ea.due));
                end
            end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                n_tot++;
                $display("FAIL A_missing_rvalid: rvalid=0 at cycle %0d, expected 0x%08h", cyc, qa[0].data);
                void'(qa.pop_front());
            end
            if (RVALID_B) begin
                if (qb.size() == 0) begin
                    n_tot++;
                    $display("FAIL B_unexpected_rvalid: Q_B=0x%08h, expected no result at cycle %0d", Q_B, cyc);
                end else begin
                    eb = qb.pop_front();
                    chk("B_data", Q_B, eb.data);
                    chk("B_latency", DW'(cyc), DW'(eb.due));
                end
            end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                n_tot++;
                $display("FAIL B_missing_rvalid: rvalid=0 at cycle %0d, expected 0x%08h", cyc, qb[0].data);
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        INITN = 1'b0;
        // Write pending on word 5 throughout reset must be dropped
        op_a(1'b0, 12'h014, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            chk("rst_Q_A", Q_A, 32'h0);
            chk("rst_RVALID_A", DW'(RVALID_A), 32'h0);
            chk("rst_Q_B", Q_B, 32'h0);
            chk("rst_RVALID_B", DW'(RVALID_B), 32'h0);
        end
        step();
        INITN = 1'b1;
        op_a(1'b1, 12'h014, 32'h0, 4'h0, 32'h0, 1'b1);
        step();

        // Latency and output hold
        op_a(1'b0, 12'h010, 32'h11223344, 4'hF, 32'h11223344, 1'b1);
        step();
        op_a(1'b1, 12'h010, 32'h0, 4'h0, 32'h11223344, 1'b1);
        step();
        repeat (6) step();
        chk("A_hold_Q", Q_A, 32'h11223344);
        chk("A_hold_RVALID", DW'(RVALID_A), 32'h0);

        // Byte enables
        op_a(1'b0, 12'h020, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 1'b1);
        step();
        op_a(1'b0, 12'h020, 32'h11223344, 4'b0101, 32'hAA22CC44, 1'b1);
        step();
        op_a(1'b1, 12'h020, 32'h0, 4'h0, 32'hAA22CC44, 1'b1);
        step();

        // Write/write collision, both ports see the merged word
        op_a(1'b0, 12'h030, 32'hFFFFFFFF, 4'b0011, 32'h1234FFFF, 1'b1);
        op_b(1'b0, 12'h030, 32'h12345678, 4'b1110, 32'h1234FFFF, 1'b1);
        step();
        op_b(1'b1, 12'h032, 32'h0, 4'h0, 32'h1234FFFF, 1'b1);
        step();

        // Write/read collision: reader gets the old word, writer gets the new one
        op_a(1'b0, 12'h040, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b1);
        op_b(1'b1, 12'h040, 32'h0, 4'h0, 32'h0, 1'b1);
        step();
        op_b(1'b0, 12'h040, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1);
        step();
        op_a(1'b1, 12'h041, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1);
        op_b(1'b1, 12'h040, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1);
        step();

        // Top word, ignored low address bits, no aliasing onto word 0
        op_a(1'b0, 12'hFFC, 32'h5A5AA5A5, 4'hF, 32'h5A5AA5A5, 1'b1);
        step();
        op_b(1'b1, 12'hFFF, 32'h0, 4'h0, 32'h5A5AA5A5, 1'b1);
        op_a(1'b1, 12'h000, 32'h0, 4'h0, 32'h0, 1'b1);
        step();
        repeat (LAT + 2) step();
        chk("B_hold_Q", Q_B, 32'h5A5AA5A5);

        // Reset pulse with reads in flight on B
        op_b(1'b1, 12'h010, 32'h0, 4'h0, 32'h0, 1'b0);
        step();
        op_b(1'b1, 12'h020, 32'h0, 4'h0, 32'h0, 1'b0);
        step();
        INITN = 1'b0;
        op_b(1'b1, 12'h030, 32'h0, 4'h0, 32'h0, 1'b0);
        #1;
        chk("midrst_Q_B_async", Q_B, 32'h0);
        step();
        INITN = 1'b1;
        chk("midrst_Q_B", Q_B, 32'h0);
        chk("midrst_RVALID_B", DW'(RVALID_B), 32'h0);
        repeat (LAT + 2) step();
        chk("midrst_Q_B_after", Q_B, 32'h0);
        op_b(1'b1, 12'h020, 32'h0, 4'h0, 32'hAA22CC44, 1'b1);
        step();
        op_b(1'b1, 12'h010, 32'h0, 4'h0, 32'h11223344, 1'b1);
        step();

        for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) step();
        while (qa.size() > 0) begin
            n_tot++;
            $display("FAIL A_drain: result 0x%08h never returned", qa[0].data);
            void'(qa.pop_front());
        end
        while (qb.size() > 0) begin
            n_tot++;
            $display("FAIL B_drain: result 0x%08h never returned", qb[0].data);
            void'(qb.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
